// File: rtl/correlator_sequencer_if.sv
// Control handshake, result display and ROM read port of the correlator sequencer.
// The slave modport is the sequencer; the master modport is the host plus ROM.
interface correlator_sequencer_if #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned FIELD_W = 3,
    parameter int unsigned ACC_W   = 9
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic                   start;
    logic                   abort;
    logic [1:0]             len_sel;
    logic                   rom_en;
    logic [AW-1:0]          rom_addr;
    logic [2*FIELD_W-1:0]   rom_data;
    logic                   busy;
    logic                   done;
    logic [ACC_W-1:0]       result;
    logic [6:0]             seg;

    modport master (
        output start, abort, len_sel, rom_data,
        input  rom_en, rom_addr, busy, done, result, seg
    );

    modport slave (
        input  start, abort, len_sel, rom_data,
        output rom_en, rom_addr, busy, done, result, seg
    );
endinterface

// File: rtl/correlator_sequencer.sv
// One-multiplier correlator: streams N = 2^len_sel ROM words, sums a*b per word,
// and reports the sum in binary and as an active-low 7-segment digit.
module correlator_sequencer #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned FIELD_W = 3,
    parameter int unsigned ACC_W   = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    correlator_sequencer_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = 2 * FIELD_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [AW-1:0]      r_cnt;
    logic [AW-1:0]      r_last;
    logic               r_v;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_result;

    logic               w_rom_en;
    logic               w_busy;
    logic               w_done;
    logic               w_accept;
    logic               w_abort;
    logic [AW-1:0]      w_len_last;
    logic [PW-1:0]      w_prod;
    logic [ACC_W-1:0]   w_acc_next;
    logic [6:0]         w_seg;

    assign w_len_last = AW'((32'd1 << bus.len_sel) - 32'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_rom_en = 1'b0;
        w_busy   = 1'b1;
        w_done   = 1'b0;
        w_accept = 1'b0;
        w_abort  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                w_rom_en = 1'b1;
                if (bus.abort) begin
                    w_abort = 1'b1;
                    w_next  = S_IDLE;
                end else if (r_cnt == r_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.abort) begin
                    w_abort = 1'b1;
                    w_next  = S_IDLE;
                end else begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_busy = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_prod = {{FIELD_W{1'b0}}, bus.rom_data[FIELD_W-1:0]}
                  * {{FIELD_W{1'b0}}, bus.rom_data[PW-1:FIELD_W]};

    always_comb begin
        w_acc_next = r_acc;
        if (r_v) begin
            w_acc_next = r_acc + ACC_W'(w_prod);
        end
    end

    // result is loaded with the final accumulate on the DRAIN->DONE edge so it is
    // already valid while done is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_last   <= '0;
            r_v      <= 1'b0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            r_v <= w_rom_en && !w_abort;
            if (w_accept) begin
                r_cnt  <= '0;
                r_last <= w_len_last;
                r_acc  <= '0;
            end else if (w_abort) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else begin
                r_acc <= w_acc_next;
                if (w_rom_en) begin
                    r_cnt <= r_cnt + AW'(1);
                end
            end
            if (r_state == S_DRAIN && !w_abort) begin
                r_result <= w_acc_next;
            end
        end
    end

    always_comb begin
        w_seg = 7'b1111110;
        if (r_result <= ACC_W'(9)) begin
            case (r_result[3:0])
                4'd0:    w_seg = 7'b0000001;
                4'd1:    w_seg = 7'b1001111;
                4'd2:    w_seg = 7'b0010010;
                4'd3:    w_seg = 7'b0000110;
                4'd4:    w_seg = 7'b1001100;
                4'd5:    w_seg = 7'b0100100;
                4'd6:    w_seg = 7'b0100000;
                4'd7:    w_seg = 7'b0001111;
                4'd8:    w_seg = 7'b0000000;
                4'd9:    w_seg = 7'b0000100;
                default: w_seg = 7'b1111110;
            endcase
        end
    end

    assign bus.rom_en   = w_rom_en;
    assign bus.rom_addr = w_rom_en ? r_cnt : '0;
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.result   = r_result;
    assign bus.seg      = w_seg;
endmodule

// File: tb/tb_correlator_sequencer.sv
// Directed bench for correlator_sequencer with a synchronous ROM model.
module tb_correlator_sequencer;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   en_cnt;
    int   done_cnt;
    logic [2:0] addr_log [0:1023];
    logic [5:0] rom [0:7];

    correlator_sequencer_if #(.DEPTH(8), .FIELD_W(3), .ACC_W(9)) bus ();

    correlator_sequencer #(.DEPTH(8), .FIELD_W(3), .ACC_W(9)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial bus.rom_data = '0;
    always @(posedge clk) begin
        if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr];
    end

    initial begin
        en_cnt   = 0;
        done_cnt = 0;
    end
    always @(negedge clk) begin
        if (bus.rom_en) begin
            if (en_cnt < 1024) addr_log[en_cnt] = bus.rom_addr;
            en_cnt = en_cnt + 1;
        end
        if (bus.done) done_cnt = done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int mode);
        for (int k = 0; k < 8; k++) begin
            logic [2:0] kk;
            kk = 3'(k);
            case (mode)
                0:       rom[k] = 6'b001001;
                1:       rom[k] = {kk, 3'd7};
                default: rom[k] = 6'b111111;
            endcase
        end
    endtask

    task automatic run(input int l, input int exp_res, input logic [6:0] exp_seg,
                       input bit disturb, input string tag);
        int n;
        int e0;
        int d0;
        int lat;
        bit got;
        n   = 1 << l;
        e0  = en_cnt;
        d0  = done_cnt;
        lat = 0;
        got = 1'b0;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.len_sel = 2'(l);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk($sformatf("%s busy_after_start", tag), 32'(bus.busy), 1);
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (disturb && i == 0) begin
                bus.start   = 1'b1;
                bus.len_sel = (l == 3) ? 2'd0 : 2'd3;
            end
            if (disturb && i == 1) bus.start = 1'b0;
            if (bus.done) got = 1'b1;
        end
        chk($sformatf("%s latency", tag), got ? 32'(lat) : 32'd999, 32'(n + 1));
        chk($sformatf("%s result", tag), 32'(bus.result), 32'(exp_res));
        chk($sformatf("%s seg", tag), 32'(bus.seg), 32'(exp_seg));
        chk($sformatf("%s busy_in_done", tag), 32'(bus.busy), 1);
        chk($sformatf("%s rom_en_in_done", tag), 32'(bus.rom_en), 0);
        @(posedge clk); #1;
        chk($sformatf("%s done_pulse_width", tag), 32'(bus.done), 0);
        chk($sformatf("%s busy_idle", tag), 32'(bus.busy), 0);
        chk($sformatf("%s done_count", tag), 32'(done_cnt - d0), 1);
        chk($sformatf("%s rom_en_cycles", tag), 32'(en_cnt - e0), 32'(n));
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s addr%0d", tag, i), 32'(addr_log[e0 + i]), 32'(i));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.len_sel = 2'd0;
        fill(0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", 32'(bus.busy), 0);
        chk("rst done", 32'(bus.done), 0);
        chk("rst rom_en", 32'(bus.rom_en), 0);
        chk("rst rom_addr", 32'(bus.rom_addr), 0);
        chk("rst result", 32'(bus.result), 0);
        chk("rst seg", 32'(bus.seg), 32'(7'b0000001));
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of an N=8 run
        d0 = done_cnt;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.len_sel = 2'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("midrst rom_en_before", 32'(bus.rom_en), 1);
        rst = 1'b1;
        #1;
        chk("midrst busy", 32'(bus.busy), 0);
        chk("midrst rom_en", 32'(bus.rom_en), 0);
        chk("midrst rom_addr", 32'(bus.rom_addr), 0);
        chk("midrst done", 32'(bus.done), 0);
        chk("midrst result", 32'(bus.result), 0);
        chk("midrst seg", 32'(bus.seg), 32'(7'b0000001));
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("midrst no_done", 32'(done_cnt - d0), 0);
        run(3, 8, 7'b0000000, 1'b0, "after_rst");

        fill(0);
        run(0, 1, 7'b1001111, 1'b0, "ones_n1");
        run(1, 2, 7'b0010010, 1'b0, "ones_n2");
        run(2, 4, 7'b1001100, 1'b0, "ones_n4");
        run(3, 8, 7'b0000000, 1'b0, "ones_n8");

        fill(1);
        run(3, 196, 7'b1111110, 1'b0, "ramp_n8");

        fill(2);
        run(3, 392, 7'b1111110, 1'b0, "max_n8");

        fill(0);
        run(2, 4, 7'b1001100, 1'b1, "ignore_start");

        // Abort in cycle 3 of an N=8 run; result must keep the value 4
        d0 = done_cnt;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.len_sel = 2'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        chk("abort busy", 32'(bus.busy), 0);
        chk("abort rom_en", 32'(bus.rom_en), 0);
        repeat (12) @(posedge clk);
        #1;
        chk("abort no_done", 32'(done_cnt - d0), 0);
        chk("abort result_held", 32'(bus.result), 4);
        run(3, 8, 7'b0000000, 1'b0, "after_abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/correlator_sequencer.md
# correlator_sequencer

Sequential controller for the ROM-based correlator datapath: on a start request it walks N = 2^len_sel ROM entries one per clock, multiplies the two 3-bit fields of each entry, and accumulates the sum. It shares one synchronous ROM read port and presents the result both as a binary value and as a 7-segment digit. It replaces the fully combinational sum-of-products with a one-multiplier schedule and adds a start/busy/done handshake.

## Interface
- DEPTH, 8: ROM entries; maximum N; power of two.
- FIELD_W, 3: width of each operand field; ROM word is 2*FIELD_W.
- ACC_W, 9: accumulator/result width; holds DEPTH*(2^FIELD_W-1)^2 = 392.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a correlation; sampled only in IDLE.
- abort  in  1  cancel a run in progress; sampled in RUN/DRAIN.
- len_sel  in  2  N = 1<<len_sel (1,2,4,8); latched when start is accepted.
- rom_en  out  1  ROM read enable.
- rom_addr  out  3  ROM read address.
- rom_data  in  6  ROM word, valid one cycle after rom_en/rom_addr; [2:0]=a, [5:3]=b.
- busy  out  1  high from start acceptance until done.
- done  out  1  single-cycle pulse, result valid.
- result  out  ACC_W  last completed sum; held until next done.
- seg  out  7  active-low abcdefg digit of result.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: busy=0, rom_en=0. start=1 -> latch N, cnt=0, acc=0, go RUN.
- RUN: rom_en=1, rom_addr=cnt, cnt++ each cycle. After issuing address N-1, go DRAIN.
- Pipeline valid bit v = registered rom_en. When v=1: acc += a*b, with a 6-bit unsigned product zero-extended to ACC_W. No saturation is needed at the defaults.
- DRAIN: rom_en=0; performs the final accumulate, then go DONE.
- DONE: result <= acc, done=1 for one cycle, go IDLE. busy is still 1 during DONE.
- abort=1 in RUN or DRAIN: go IDLE next edge, clear v and acc, no done pulse, result unchanged. abort in IDLE/DONE is ignored.
- start while not in IDLE is ignored, not queued. len_sel changes after acceptance are ignored.
- seg is decoded from the registered result:
  - 0: 0000001
  - 1: 1001111
  - 2: 0010010
  - 3: 0000110
  - 4: 1001100
  - 5: 0100100
  - 6: 0100000
  - 7: 0001111
  - 8: 0000000
  - 9: 0000100
  - result > 9: dash, 1111110.
- Reset (any state, any time): state=IDLE, cnt=0, v=0, acc=0, rom_en=0, rom_addr=0, busy=0, done=0, result=0, seg=0000001. A run interrupted by reset produces no done.

## Timing
- Edge E0 samples start=1. Then rom_addr=k is driven during cycle k after E0, for k=0..N-1.
- rom_data for address k is used at edge E(k+2).
- acc is final after E(N+1). done and result are valid in the cycle after E(N+1).
- Latency from start edge to done: N+1 cycles (2, 3, 5, 9 for len_sel 0..3).
- busy: asserted from E0 through the DONE cycle (N+2 cycles), deasserted with the return to IDLE.
- Minimum start-to-start spacing: N+2 cycles. start held high continuously re-triggers on the first IDLE cycle.
- rom_en is never high in IDLE, DRAIN, or DONE.

## Test plan
- Reset mid-RUN (ROM all 6'b001001, len_sel=3, rst pulsed at cycle 4) -> outputs immediately at reset values, seg=0000001, no done; a fresh start afterwards yields result=8.
- ROM all 6'b001001 (a=b=1), each len_sel 0..3 -> done after 2/3/5/9 cycles, result 1/2/4/8, seg digit matches.
- ROM[k] = {k[2:0], 3'd7}, len_sel=3 -> result = 7*(0+...+7) = 196, seg=1111110, done 9 cycles after start.
- ROM all 6'b111111, len_sel=3 -> result=392; no overflow; rom_addr sequence 0..7 with rom_en high exactly 8 cycles.
- start pulsed again and len_sel toggled during busy -> ignored; single done, result reflects the latched N.
- abort asserted during cycle 3 of an N=8 run -> returns to IDLE next cycle, no done, result keeps its prior value; next start completes normally.
